// File: rtl/loader_pkg.sv
// Shared definitions for the serial boot loader: FSM states, default frame marker,
// header field positions and the length-field decode.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN,
    DATA,
    CSUM
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Byte positions within a frame header.
  localparam int FIELD_SYNC    = 0;
  localparam int FIELD_ADDR_HI = 1;
  localparam int FIELD_ADDR_LO = 2;
  localparam int FIELD_LEN     = 3;
  localparam int HEADER_BYTES  = 4;

  // A length byte of zero encodes a full 256-byte payload.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Inter-byte idle timer for the boot loader: clearable counter that saturates at
// timeout_cycles-1 and flags expiry while it sits there uncleared.
module loader_timer #(
  parameter int timeout_cycles = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int CW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(timeout_cycles - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign expire = ~clear & (count == LIMIT);

endmodule

// File: rtl/d_ram_loader.sv
// Serial-to-RAM boot loader: parses sync/addr/len/data frames from a byte stream and
// writes the payload into data RAM. Trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module d_ram_loader
  import loader_pkg::*;
#(
  parameter int         addr_width     = 12,
  parameter logic [7:0] sync_byte      = DEFAULT_SYNC_BYTE,
  parameter int         timeout_cycles = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [addr_width-1:0] w_addr,
  output logic [7:0]            din,
  output logic                  w_en,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam int HI_W = addr_width - 8;

  state_t                state, state_next;
  logic [HI_W-1:0]       addr_hi, addr_hi_next;
  logic [addr_width-1:0] pointer, pointer_next;
  logic [addr_width-1:0] w_addr_next;
  logic [8:0]            count, count_next;
  logic [7:0]            din_next;
  logic                  w_en_next, done_next, err_next;
  logic                  accept, expire, timer_clear;

  assign accept      = in_valid & in_ready;
  assign busy        = (state != IDLE);
  assign cpu_hold    = busy;
  assign timer_clear = accept | (state == IDLE);

  loader_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum, csum_next;
  logic       csum_match;

  assign csum_match = (in_data == csum);

  // Running sum covers every header field after sync plus all payload bytes.
  always_comb begin
    csum_next = csum;
    if (accept) begin
      case (state)
        IDLE:                    if (in_data == sync_byte) csum_next = 8'd0;
        ADDR_HI, ADDR_LO, LEN,
        DATA:                    csum_next = csum + in_data;
        default:                 csum_next = csum;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= 8'd0;
    end else begin
      csum <= csum_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_hi <= '0;
      pointer <= '0;
      count   <= '0;
      w_addr  <= '0;
      din     <= 8'd0;
      w_en    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      addr_hi <= addr_hi_next;
      pointer <= pointer_next;
      count   <= count_next;
      w_addr  <= w_addr_next;
      din     <= din_next;
      w_en    <= w_en_next;
      done    <= done_next;
      err     <= err_next;
    end
  end

  // Frame parser; the RAM write and done/err pulses are registered so each
  // accepted payload byte reaches the RAM exactly one cycle later.
  always_comb begin
    state_next   = state;
    addr_hi_next = addr_hi;
    pointer_next = pointer;
    count_next   = count;
    w_addr_next  = w_addr;
    din_next     = din;
    w_en_next    = 1'b0;
    done_next    = 1'b0;
    err_next     = 1'b0;

    if (accept) begin
      case (state)
        IDLE: begin
          if (in_data == sync_byte) state_next = ADDR_HI;
        end
        ADDR_HI: begin
          addr_hi_next = in_data[HI_W-1:0];
          state_next   = ADDR_LO;
        end
        ADDR_LO: begin
          pointer_next = {addr_hi, in_data};
          state_next   = LEN;
        end
        LEN: begin
          count_next = len_to_count(in_data);
          state_next = DATA;
        end
        DATA: begin
          w_en_next    = 1'b1;
          w_addr_next  = pointer;
          din_next     = in_data;
          pointer_next = pointer + addr_width'(1);
          count_next   = count - 9'd1;
          if (count == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = IDLE;
            done_next  = 1'b1;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          done_next  = csum_match;
          err_next   = ~csum_match;
          state_next = IDLE;
        end
`endif
        default: state_next = IDLE;
      endcase
    end

    // Expiry only happens on a cycle with no accepted byte, so it never collides with done.
    if (expire) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end
  end

endmodule

// File: tb/tb_d_ram_loader.sv
// Scoreboard bench for d_ram_loader: stimulus pushes expected RAM writes and done/err
// events; a negedge monitor pops and compares. Expectations follow LOADER_CHECKSUM_EN.
module tb_d_ram_loader;

  localparam int AW      = 12;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

`ifdef LOADER_CHECKSUM_EN
  localparam int BAD_CSUM_EV = EV_ERR;
`else
  localparam int BAD_CSUM_EV = EV_DONE;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] w_addr;
  logic [7:0]    din;
  logic          w_en;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;

  wr_t        exp_wr[$];
  int         exp_ev[$];
  logic [7:0] frame[$];

  d_ram_loader #(
    .addr_width    (AW),
    .sync_byte     (8'hA5),
    .timeout_cycles(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .w_addr  (w_addr),
    .din     (din),
    .w_en    (w_en),
    .busy    (busy),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    foreach (frame[i]) applyStimulus(frame[i]);
    in_valid = 1'b0;
    frame.delete();
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [7:0] d);
    exp_wr.push_back('{addr: a, data: d});
  endtask

  // Bounded wait for the monitor to consume all outstanding expectations.
  task automatic drain(input string name);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_ev.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "_writes_left"}, exp_wr.size(), 0);
    checkOutput({name, "_events_left"}, exp_ev.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (w_en) begin
        if (exp_wr.size() == 0) begin
          checkOutput("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          checkOutput("write_addr", w_addr, e.addr);
          checkOutput("write_data", din, e.data);
        end
      end
      if (done || err) begin
        checkOutput("done_err_exclusive", done & err, 32'd0);
        if (exp_ev.size() == 0) begin
          checkOutput("unexpected_event", done ? EV_DONE : EV_ERR, 32'd0);
        end else begin
          checkOutput("event_kind", done ? EV_DONE : EV_ERR, exp_ev.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_w_en", w_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cpu_hold", cpu_hold, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_w_addr", w_addr, 0);
    checkOutput("rst_din", din, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_busy", busy, 0);

    $display("[TB] junk bytes then 3-byte frame");
    frame = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
    push_write(12'h010, 8'h11);
    push_write(12'h011, 8'h22);
    push_write(12'h012, 8'h33);
    exp_ev.push_back(EV_DONE);
    send_frame();
    drain("basic");
    checkOutput("basic_busy_after", busy, 0);

    $display("[TB] address wrap with addr_hi upper bits set");
    frame = '{8'hA5, 8'h0F, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h75};
    push_write(12'hFFF, 8'hAA);
    push_write(12'h000, 8'hBB);
    exp_ev.push_back(EV_DONE);
    send_frame();
    drain("wrap");

    $display("[TB] len=0 frame of 256 bytes");
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    for (int i = 0; i < 256; i++) push_write(AW'(i), 8'(i));
    exp_ev.push_back(EV_DONE);
    for (int i = 0; i < 128; i++) applyStimulus(8'(i));
    checkOutput("long_busy_mid", busy, 1);
    checkOutput("long_cpu_hold_mid", cpu_hold, 1);
    for (int i = 128; i < 256; i++) applyStimulus(8'(i));
    applyStimulus(8'h80);
    in_valid = 1'b0;
    drain("long");
    checkOutput("long_busy_after", busy, 0);

    $display("[TB] bad checksum frame");
    frame = '{8'hA5, 8'h00, 8'h20, 8'h01, 8'h44, 8'h00};
    push_write(12'h020, 8'h44);
    exp_ev.push_back(BAD_CSUM_EV);
    send_frame();
    drain("badcsum");
    checkOutput("badcsum_busy_after", busy, 0);

    $display("[TB] stalled frame times out");
    frame = '{8'hA5, 8'h00, 8'h30, 8'h02, 8'h55};
    push_write(12'h030, 8'h55);
    exp_ev.push_back(EV_ERR);
    send_frame();
    idle_cycles(1);
    checkOutput("timeout_cpu_hold_wait", cpu_hold, 1);
    idle_cycles(20);
    checkOutput("timeout_cpu_hold_after", cpu_hold, 0);
    drain("timeout");

    $display("[TB] reset mid-data");
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h50);
    applyStimulus(8'h04);
    push_write(12'h050, 8'h01);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("midrst_w_en", w_en, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_cpu_hold", cpu_hold, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_writes_left", exp_wr.size(), 0);

    $display("[TB] full frame after reset");
    frame = '{8'hA5, 8'h00, 8'h40, 8'h02, 8'h66, 8'h77, 8'h1F};
    push_write(12'h040, 8'h66);
    push_write(12'h041, 8'h77);
    exp_ev.push_back(EV_DONE);
    send_frame();
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
